// File: rtl/mul_pkg.sv
// Shared types and helpers for the M-extension multiply controller.
package mul_pkg;

  // RV32M multiply opcodes as presented by the dispatch stage
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } mul_state_e;

  // Operand signedness for the multiplier: [1]=a signed, [0]=b signed
  function automatic logic [1:0] sign_map(input mul_op_e op);
    logic [1:0] s;
    case (op)
      OP_MUL, OP_MULH: s = 2'b11;
      OP_MULHSU:       s = 2'b10;
      default:         s = 2'b00;
    endcase
    return s;
  endfunction

  // MUL takes the low word; every high-half op takes the upper word
  function automatic logic [31:0] half_sel(input mul_op_e op, input logic [63:0] prod);
    return (op == OP_MUL) ? prod[31:0] : prod[63:32];
  endfunction

endpackage

// File: rtl/mul_result_cache.sv
// One-entry operand/product cache so a MULH/MUL pair on the same operands
// only runs the multiplier once.
module mul_result_cache
  import mul_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] lookup_a,
  input  logic [31:0] lookup_b,
  input  logic [1:0]  lookup_sign,
  input  mul_op_e     lookup_op,
  output logic        hit,
  output logic [63:0] hit_prod,
  input  logic        wr_en,
  input  logic [31:0] wr_a,
  input  logic [31:0] wr_b,
  input  logic [1:0]  wr_sign,
  input  logic [63:0] wr_prod
);

  logic        valid_q;
  logic [31:0] key_a_q;
  logic [31:0] key_b_q;
  logic [1:0]  key_sign_q;
  logic [63:0] prod_q;

  // Capture a fresh product; the entry is only ever cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      key_a_q    <= '0;
      key_b_q    <= '0;
      key_sign_q <= '0;
      prod_q     <= '0;
    end else if (wr_en) begin
      valid_q    <= 1'b1;
      key_a_q    <= wr_a;
      key_b_q    <= wr_b;
      key_sign_q <= wr_sign;
      prod_q     <= wr_prod;
    end
  end

  // The low word is sign-independent, so MUL may reuse any cached product;
  // high-half ops need the exact signedness that produced the entry.
  always_comb begin
    hit = CACHE_EN && valid_q && (lookup_a == key_a_q) && (lookup_b == key_b_q)
          && ((lookup_op == OP_MUL) || (lookup_sign == key_sign_q));
    hit_prod = prod_q;
  end

endmodule

// File: rtl/mul_ctrl.sv
// Sequencing controller between M-extension dispatch and the iterative
// multiplier: sign decode, zero shortcut, product reuse and flush handling.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter bit CACHE_EN    = 1'b1,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        mul_in_valid,
  input  logic        mul_in_ready,
  output logic [1:0]  mul_in_sign,
  output logic [31:0] mul_in_a,
  output logic [31:0] mul_in_b,
  input  logic        mul_out_valid,
  output logic        mul_out_ready,
  input  logic [63:0] mul_out_prod,
  output logic        mul_flush
);

  mul_state_e  state_q;
  mul_op_e     op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  sign_q;
  logic [31:0] result_q;

  mul_op_e     in_op_e;
  logic [1:0]  in_sign;
  logic        zero_hit;
  logic        cache_hit;
  logic [63:0] cache_prod;
  logic        cache_wr;

  // Decode of the incoming request used for the accept-cycle decisions
  always_comb begin
    in_op_e  = mul_op_e'(in_op);
    in_sign  = sign_map(in_op_e);
    zero_hit = ZERO_BYPASS && ((in_a == 32'd0) || (in_b == 32'd0));
    cache_wr = (state_q == ST_WAIT) && mul_out_valid && !flush;
  end

  mul_result_cache #(
    .CACHE_EN(CACHE_EN)
  ) u_cache (
    .clock      (clock),
    .reset      (reset),
    .lookup_a   (in_a),
    .lookup_b   (in_b),
    .lookup_sign(in_sign),
    .lookup_op  (in_op_e),
    .hit        (cache_hit),
    .hit_prod   (cache_prod),
    .wr_en      (cache_wr),
    .wr_a       (a_q),
    .wr_b       (b_q),
    .wr_sign    (sign_q),
    .wr_prod    (mul_out_prod)
  );

  // Main sequencer: one request in flight, flush always returns to IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= '0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q   <= in_op_e;
            a_q    <= in_a;
            b_q    <= in_b;
            sign_q <= in_sign;
            if (zero_hit) begin
              result_q <= 32'd0;
              state_q  <= ST_RESP;
            end else if (cache_hit) begin
              result_q <= half_sel(in_op_e, cache_prod);
              state_q  <= ST_RESP;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (mul_in_ready) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mul_out_valid) begin
            result_q <= half_sel(op_q, mul_out_prod);
            state_q  <= ST_RESP;
          end
        end
        default: begin
          if (out_ready) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decoded from state; flush only masks or forwards
  always_comb begin
    in_ready      = (state_q == ST_IDLE) && !flush;
    out_valid     = (state_q == ST_RESP) && !flush;
    out_result    = result_q;
    mul_in_valid  = (state_q == ST_ISSUE);
    mul_in_sign   = sign_q;
    mul_in_a      = a_q;
    mul_in_b      = b_q;
    mul_out_ready = (state_q == ST_WAIT);
    mul_flush     = flush && ((state_q == ST_ISSUE) || (state_q == ST_WAIT));
  end

endmodule
